multicycle_main_controller: RTL and testbench
=============================================

Name: multicycle_main_controller

Overview:
Parametrised multicycle successor to the single-cycle main decoder. A Moore FSM sequences each MIPS instruction (R-type, lw, sw, beq, addi, j, optional bne) across FETCH/DECODE/EXECUTE/MEM/WB cycles. It drives the shared-memory datapath's mux selects and write strobes, stalls on a memory-ready handshake, flags illegal opcodes and counts retired instructions.

Parameters:
MEM_WAIT, 1, 1: fetch and memory states hold until mem_ready=1; 0: memory is single-cycle and mem_ready is ignored
HAS_BNE, 1, 1: opcode 6'b000101 (bne) is legal; 0: it is treated as illegal
TRAP_ON_ILLEGAL, 0, 1: an illegal opcode enters sticky HALT; 0: skip the instruction and refetch
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
op  in  6  opcode IR[31:26]; stable outside FETCH
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
pc_en  out  1  PC write enable (pc_write | branch-taken)
iord  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  1  destination register: 0=rt, 1=rd
mem_to_reg  out  1  write-back data: 0=ALUOut, 1=MDR
reg_write  out  1  register-file write enable
alu_src_a  out  1  ALU A: 0=PC, 1=rs
alu_src_b  out  2  ALU B: 00=rt, 01=4, 10=sign-extended imm, 11=imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct (same encoding as the single-cycle decoder)
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  out  1  high while in ILLEGAL or HALT
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset: synchronous. rst_n=0 at a clk edge sets state=FETCH and retired=0. While rst_n=0, pc_en, ir_write, mem_read, mem_write and reg_write are forced to 0.
- All outputs are decoded from the state register only; pc_en also uses zero. Unlisted outputs are 0.
- FETCH: mem_read=1, iord=0, a=0, b=01, alu_op=00, pc_src=00.
  - ir_write=pc_write=rdy, where rdy=mem_ready if MEM_WAIT else 1.
  - rdy -> DECODE; otherwise hold.
- DECODE: a=0, b=11, alu_op=00 (branch target into ALUOut). Next state by op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BEQ
  - 000101 (only if HAS_BNE) -> BNE
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other op -> ILLEGAL
- MEMADR: a=1, b=10, alu_op=00. op=100011 -> MEMRD; op=101011 -> MEMWR.
- MEMRD: mem_read=1, iord=1. rdy -> MEMWB; otherwise hold.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. -> FETCH, retire.
- MEMWR: mem_write=1, iord=1; strobe held until rdy. rdy -> FETCH, retire.
- EXEC: a=1, b=00, alu_op=10. -> ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH, retire.
- BEQ: a=1, b=00, alu_op=01, pc_src=01, pc_en=zero. -> FETCH, retire.
- BNE: as BEQ but pc_en=~zero. -> FETCH, retire.
- ADDIEX: a=1, b=10, alu_op=00. -> ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH, retire.
- JUMP: pc_src=10, pc_en=1. -> FETCH, retire.
- ILLEGAL: illegal_op=1, one cycle. TRAP_ON_ILLEGAL=1 -> HALT; otherwise -> FETCH with no retire.
- HALT: illegal_op=1, all strobes 0, stays until reset.
- Retire: retired increments by 1 at the clk edge leaving a retiring state. It wraps modulo 2^CNT_W.
- Latency with MEM_WAIT=0, in cycles: lw 5; sw, R-type, addi 4; beq, bne, j 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Strobes and selects stay constant during the wait.
- Reset mid-instruction: abandon the instruction, no retire, next cycle is FETCH.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - state_t enum (4-bit)
  - alu_op, alu_src_b and pc_src encodings
  - packed ctrl_t struct carrying all strobes and selects
- Sub-module ctrl_state_decode: purely combinational, state_t -> ctrl_t. The top module holds only the state register, next-state logic, the rdy/reset gating, pc_en and the counter.

Test Plan:
- MEM_WAIT=0; op=000000 after reset -> states FETCH, DECODE, EXEC, ALUWB, FETCH; reg_write=1 and reg_dst=1 only in cycle 4; retired=1.
- MEM_WAIT=1, op=100011, mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> lw completes in 10 cycles; ir_write=1 only in the mem_ready cycle; mem_to_reg=1 in MEMWB; retired +1.
- beq with zero=1, then beq with zero=0 -> pc_en=1 with pc_src=01, then pc_en=0; HAS_BNE=1 bne with zero=0 -> pc_en=1; all three retire.
- op=111111 with TRAP_ON_ILLEGAL=0 -> illegal_op pulses 1 cycle, back to FETCH, retired unchanged. With TRAP_ON_ILLEGAL=1 -> illegal_op stays 1 and no strobes for 20 cycles. With HAS_BNE=0, op=000101 -> illegal.
- sw with mem_ready=0 for 4 cycles in MEMWR, then rst_n=0 -> mem_write=1 throughout the wait, 0 during reset; FETCH follows; retired=0.
- CNT_W=4: 16 j instructions from reset -> retired returns to 0; pc_en=1 and pc_src=10 in each JUMP state.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main controller: opcode values,
// FSM state encoding, datapath select encodings and the packed control word
// that the state decoder hands to the top-level controller.
// Ports: none (package).
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

   // Opcodes (IR[31:26]) recognised by the controller
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU operation encoding, shared with the single-cycle decoder
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B operand select
   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   // Next-PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQ     = 4'd8,
      S_BNE     = 4'd9,
      S_ADDIEX  = 4'd10,
      S_ADDIWB  = 4'd11,
      S_JUMP    = 4'd12,
      S_ILLEGAL = 4'd13,
      S_HALT    = 4'd14
   } state_t;

   // Raw per-state control word. pcWrite/irWrite are still ungated by the
   // memory handshake; waitMem marks states that hold for mem_ready and
   // retire marks states whose exit completes an instruction.
   typedef struct packed {
      logic       memRead;
      logic       iord;
      logic       memWrite;
      logic       irWrite;
      logic       pcWrite;
      logic       branchEq;
      logic       branchNe;
      logic       regDst;
      logic       memToReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSrc;
      logic       illegal;
      logic       waitMem;
      logic       retire;
   } ctrl_t;

endpackage

// File: rtl/ctrl_state_decode.sv
// -----------------------------------------------------------------------------
// ctrl_state_decode
// Purely combinational Moore output decoder: maps the controller state to the
// raw control word. Anything not set for a state stays 0.
// Ports:
//   i_state  current FSM state
//   o_ctrl   raw control word for that state
// -----------------------------------------------------------------------------
module ctrl_state_decode
   import mips_ctrl_pkg::*;
(
   input  state_t i_state,
   output ctrl_t  o_ctrl
);

   // Every state starts from an all-zero word so unlisted strobes stay low
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.memRead = 1'b1;
            o_ctrl.irWrite = 1'b1;
            o_ctrl.pcWrite = 1'b1;
            o_ctrl.aluSrcB = SRCB_FOUR;
            o_ctrl.aluOp   = ALU_ADD;
            o_ctrl.pcSrc   = PCSRC_ALU;
            o_ctrl.waitMem = 1'b1;
         end
         S_DECODE: begin
            o_ctrl.aluSrcB = SRCB_IMMSH2;
            o_ctrl.aluOp   = ALU_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.aluOp   = ALU_ADD;
         end
         S_MEMRD: begin
            o_ctrl.memRead = 1'b1;
            o_ctrl.iord    = 1'b1;
            o_ctrl.waitMem = 1'b1;
         end
         S_MEMWB: begin
            o_ctrl.regWrite = 1'b1;
            o_ctrl.memToReg = 1'b1;
            o_ctrl.retire   = 1'b1;
         end
         S_MEMWR: begin
            o_ctrl.memWrite = 1'b1;
            o_ctrl.iord     = 1'b1;
            o_ctrl.waitMem  = 1'b1;
            o_ctrl.retire   = 1'b1;
         end
         S_EXEC: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_RT;
            o_ctrl.aluOp   = ALU_FUNCT;
         end
         S_ALUWB: begin
            o_ctrl.regWrite = 1'b1;
            o_ctrl.regDst   = 1'b1;
            o_ctrl.retire   = 1'b1;
         end
         S_BEQ, S_BNE: begin
            o_ctrl.aluSrcA  = 1'b1;
            o_ctrl.aluSrcB  = SRCB_RT;
            o_ctrl.aluOp    = ALU_SUB;
            o_ctrl.pcSrc    = PCSRC_ALUOUT;
            o_ctrl.branchEq = (i_state == S_BEQ);
            o_ctrl.branchNe = (i_state == S_BNE);
            o_ctrl.retire   = 1'b1;
         end
         S_ADDIWB: begin
            o_ctrl.regWrite = 1'b1;
            o_ctrl.retire   = 1'b1;
         end
         S_JUMP: begin
            o_ctrl.pcSrc   = PCSRC_JUMP;
            o_ctrl.pcWrite = 1'b1;
            o_ctrl.retire  = 1'b1;
         end
         S_ILLEGAL, S_HALT: begin
            o_ctrl.illegal = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_main_controller.sv
// -----------------------------------------------------------------------------
// multicycle_main_controller
// Moore FSM sequencing MIPS instructions over a shared-memory multicycle
// datapath, with memory-ready stalls, illegal-opcode handling and a retired
// instruction counter.
// Ports:
//   i_clk, i_rst_n     clock and synchronous active-low reset
//   i_op               opcode IR[31:26]
//   i_zero             ALU zero flag (branch decision)
//   i_mem_ready        memory access completes this cycle
//   o_pc_en .. o_pc_src  datapath strobes and selects
//   o_illegal_op       high in ILLEGAL or HALT
//   o_retired          completed-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_main_controller
   import mips_ctrl_pkg::*;
#(
   parameter bit MEM_WAIT        = 1'b1,
   parameter bit HAS_BNE         = 1'b1,
   parameter bit TRAP_ON_ILLEGAL = 1'b0,
   parameter int CNT_W           = 32
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [5:0]       i_op,
   input  logic             i_zero,
   input  logic             i_mem_ready,
   output logic             o_pc_en,
   output logic             o_iord,
   output logic             o_mem_read,
   output logic             o_mem_write,
   output logic             o_ir_write,
   output logic             o_reg_dst,
   output logic             o_mem_to_reg,
   output logic             o_reg_write,
   output logic             o_alu_src_a,
   output logic [1:0]       o_alu_src_b,
   output logic [1:0]       o_alu_op,
   output logic [1:0]       o_pc_src,
   output logic             o_illegal_op,
   output logic [CNT_W-1:0] o_retired
);

   state_t           r_state;
   state_t           w_nextState;
   ctrl_t            w_ctrl;
   logic [CNT_W-1:0] r_retired;
   logic             w_rdy;
   logic             w_advance;
   logic             w_retire;

   ctrl_state_decode u_decode (
      .i_state (r_state),
      .o_ctrl  (w_ctrl)
   );

   // With single-cycle memory the handshake is ignored entirely
   assign w_rdy     = MEM_WAIT ? i_mem_ready : 1'b1;
   // Waiting states only make progress (and only fire their gated strobes)
   // in the cycle the memory reports completion
   assign w_advance = ~w_ctrl.waitMem | w_rdy;
   assign w_retire  = w_ctrl.retire & w_advance;

   // Next-state logic; op is only consulted in DECODE and MEMADR
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_FETCH:  if (w_rdy) w_nextState = S_DECODE;
         S_DECODE: begin
            case (i_op)
               OP_LW, OP_SW: w_nextState = S_MEMADR;
               OP_RTYPE:     w_nextState = S_EXEC;
               OP_BEQ:       w_nextState = S_BEQ;
               OP_BNE:       w_nextState = HAS_BNE ? S_BNE : S_ILLEGAL;
               OP_ADDI:      w_nextState = S_ADDIEX;
               OP_J:         w_nextState = S_JUMP;
               default:      w_nextState = S_ILLEGAL;
            endcase
         end
         S_MEMADR:  w_nextState = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (w_rdy) w_nextState = S_MEMWB;
         S_MEMWR:   if (w_rdy) w_nextState = S_FETCH;
         S_EXEC:    w_nextState = S_ALUWB;
         S_ADDIEX:  w_nextState = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BEQ, S_BNE, S_ADDIWB, S_JUMP:
                    w_nextState = S_FETCH;
         S_ILLEGAL: w_nextState = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
         S_HALT:    w_nextState = S_HALT;
         default:   w_nextState = S_FETCH;
      endcase
   end

   // State register and retire counter; reset abandons any instruction
   // in flight without counting it
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= S_FETCH;
         r_retired <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_retire) r_retired <= r_retired + CNT_W'(1);
      end
   end

   // Write/read strobes are forced low while reset is asserted
   always_comb begin
      o_pc_en      = i_rst_n & ((w_ctrl.pcWrite & w_advance)
                                | (w_ctrl.branchEq & i_zero)
                                | (w_ctrl.branchNe & ~i_zero));
      o_ir_write   = i_rst_n & w_ctrl.irWrite & w_advance;
      o_mem_read   = i_rst_n & w_ctrl.memRead;
      o_mem_write  = i_rst_n & w_ctrl.memWrite;
      o_reg_write  = i_rst_n & w_ctrl.regWrite;
      o_iord       = w_ctrl.iord;
      o_reg_dst    = w_ctrl.regDst;
      o_mem_to_reg = w_ctrl.memToReg;
      o_alu_src_a  = w_ctrl.aluSrcA;
      o_alu_src_b  = w_ctrl.aluSrcB;
      o_alu_op     = w_ctrl.aluOp;
      o_pc_src     = w_ctrl.pcSrc;
      o_illegal_op = w_ctrl.illegal;
      o_retired    = r_retired;
   end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_controller
// Drives two controller instances with directed per-cycle vectors:
//   dutA: MEM_WAIT=1, HAS_BNE=1, TRAP_ON_ILLEGAL=0, CNT_W=4
//   dutB: MEM_WAIT=0, HAS_BNE=0, TRAP_ON_ILLEGAL=1, CNT_W=32
// Each stimulus cycle pushes the expected outputs onto a queue; a monitor
// pops one entry every falling edge and compares against the chosen DUT.
// -----------------------------------------------------------------------------
module tb_multicycle_main_controller;

   typedef enum int {
      T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR, T_EXEC, T_ALUWB,
      T_BEQ, T_BNE, T_ADDIEX, T_ADDIWB, T_JUMP, T_ILLEGAL, T_HALT
   } tbState_t;

   typedef struct packed {
      logic        pcEn;
      logic        iord;
      logic        memRead;
      logic        memWrite;
      logic        irWrite;
      logic        regDst;
      logic        memToReg;
      logic        regWrite;
      logic        aluSrcA;
      logic [1:0]  aluSrcB;
      logic [1:0]  aluOp;
      logic [1:0]  pcSrc;
      logic        illegal;
      logic [31:0] retired;
   } outVec_t;

   typedef struct {
      outVec_t  exp;
      bit       sel;
      tbState_t st;
      int       cycle;
   } sbItem_t;

   localparam logic [5:0] OPC_R    = 6'b000000;
   localparam logic [5:0] OPC_LW   = 6'b100011;
   localparam logic [5:0] OPC_SW   = 6'b101011;
   localparam logic [5:0] OPC_BEQ  = 6'b000100;
   localparam logic [5:0] OPC_BNE  = 6'b000101;
   localparam logic [5:0] OPC_ADDI = 6'b001000;
   localparam logic [5:0] OPC_J    = 6'b000010;
   localparam logic [5:0] OPC_BAD  = 6'b111111;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dutA signals
   logic       rstA = 1'b0, zeroA = 1'b0, mrA = 1'b0;
   logic [5:0] opA = '0;
   logic       pcEnA, iordA, memReadA, memWriteA, irWriteA, regDstA;
   logic       memToRegA, regWriteA, aluSrcAA, illegalA;
   logic [1:0] aluSrcBA, aluOpA, pcSrcA;
   logic [3:0] retiredA;

   // dutB signals
   logic        rstB = 1'b0, zeroB = 1'b0, mrB = 1'b0;
   logic [5:0]  opB = '0;
   logic        pcEnB, iordB, memReadB, memWriteB, irWriteB, regDstB;
   logic        memToRegB, regWriteB, aluSrcAB, illegalB;
   logic [1:0]  aluSrcBB, aluOpB, pcSrcB;
   logic [31:0] retiredB;

   multicycle_main_controller #(
      .MEM_WAIT(1'b1), .HAS_BNE(1'b1), .TRAP_ON_ILLEGAL(1'b0), .CNT_W(4)
   ) dutA (
      .i_clk(clk), .i_rst_n(rstA), .i_op(opA), .i_zero(zeroA),
      .i_mem_ready(mrA), .o_pc_en(pcEnA), .o_iord(iordA),
      .o_mem_read(memReadA), .o_mem_write(memWriteA), .o_ir_write(irWriteA),
      .o_reg_dst(regDstA), .o_mem_to_reg(memToRegA), .o_reg_write(regWriteA),
      .o_alu_src_a(aluSrcAA), .o_alu_src_b(aluSrcBA), .o_alu_op(aluOpA),
      .o_pc_src(pcSrcA), .o_illegal_op(illegalA), .o_retired(retiredA)
   );

   multicycle_main_controller #(
      .MEM_WAIT(1'b0), .HAS_BNE(1'b0), .TRAP_ON_ILLEGAL(1'b1), .CNT_W(32)
   ) dutB (
      .i_clk(clk), .i_rst_n(rstB), .i_op(opB), .i_zero(zeroB),
      .i_mem_ready(mrB), .o_pc_en(pcEnB), .o_iord(iordB),
      .o_mem_read(memReadB), .o_mem_write(memWriteB), .o_ir_write(irWriteB),
      .o_reg_dst(regDstB), .o_mem_to_reg(memToRegB), .o_reg_write(regWriteB),
      .o_alu_src_a(aluSrcAB), .o_alu_src_b(aluSrcBB), .o_alu_op(aluOpB),
      .o_pc_src(pcSrcB), .o_illegal_op(illegalB), .o_retired(retiredB)
   );

   sbItem_t sbQ[$];
   int      assertCount = 0;
   int      failCount   = 0;
   int      cycleCount  = 0;

   // Expected outputs for one cycle, built from the controller's per-state
   // output table, then queued for the monitor
   task automatic applyStimulus(input bit sel, input tbState_t st,
                                input logic [5:0] op, input logic zero,
                                input logic mr, input logic rstN,
                                input int retExp);
      outVec_t e;
      sbItem_t item;
      logic    rdy;
      if (sel) begin
         rstB = rstN; opB = op; zeroB = zero; mrB = mr;
      end else begin
         rstA = rstN; opA = op; zeroA = zero; mrA = mr;
      end
      rdy = sel ? 1'b1 : mr;
      e = '0;
      case (st)
         T_FETCH:   begin e.memRead = 1'b1; e.aluSrcB = 2'b01;
                          e.irWrite = rdy; e.pcEn = rdy; end
         T_DECODE:  e.aluSrcB = 2'b11;
         T_MEMADR:  begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
         T_MEMRD:   begin e.memRead = 1'b1; e.iord = 1'b1; end
         T_MEMWB:   begin e.regWrite = 1'b1; e.memToReg = 1'b1; end
         T_MEMWR:   begin e.memWrite = 1'b1; e.iord = 1'b1; end
         T_EXEC:    begin e.aluSrcA = 1'b1; e.aluOp = 2'b10; end
         T_ALUWB:   begin e.regWrite = 1'b1; e.regDst = 1'b1; end
         T_BEQ:     begin e.aluSrcA = 1'b1; e.aluOp = 2'b01;
                          e.pcSrc = 2'b01; e.pcEn = zero; end
         T_BNE:     begin e.aluSrcA = 1'b1; e.aluOp = 2'b01;
                          e.pcSrc = 2'b01; e.pcEn = ~zero; end
         T_ADDIEX:  begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
         T_ADDIWB:  e.regWrite = 1'b1;
         T_JUMP:    begin e.pcSrc = 2'b10; e.pcEn = 1'b1; end
         T_ILLEGAL: e.illegal = 1'b1;
         T_HALT:    e.illegal = 1'b1;
         default:   e = '0;
      endcase
      if (!rstN) begin
         e.pcEn = 1'b0; e.irWrite = 1'b0; e.memRead = 1'b0;
         e.memWrite = 1'b0; e.regWrite = 1'b0;
      end
      e.retired  = retExp;
      item.exp   = e;
      item.sel   = sel;
      item.st    = st;
      item.cycle = cycleCount;
      sbQ.push_back(item);
      cycleCount++;
      @(posedge clk);
      #1;
   endtask

   function automatic outVec_t observe(input bit sel);
      outVec_t v;
      if (sel)
         v = {pcEnB, iordB, memReadB, memWriteB, irWriteB, regDstB, memToRegB,
              regWriteB, aluSrcAB, aluSrcBB, aluOpB, pcSrcB, illegalB, retiredB};
      else
         v = {pcEnA, iordA, memReadA, memWriteA, irWriteA, regDstA, memToRegA,
              regWriteA, aluSrcAA, aluSrcBA, aluOpA, pcSrcA, illegalA,
              28'd0, retiredA};
      return v;
   endfunction

   task automatic checkOutput(input sbItem_t item, input outVec_t act);
      assertCount++;
      if (act !== item.exp) begin
         failCount++;
         $display("[TB] FAIL cycle %0d dut%s state %s: got %h expected %h (retired got %0d expected %0d)",
                  item.cycle, item.sel ? "B" : "A", item.st.name(), act,
                  item.exp, act.retired, item.exp.retired);
      end
   endtask

   // Monitor: one expected entry per stimulus cycle, compared mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         if (sbQ.size() > 0) begin
            sbItem_t item;
            item = sbQ.pop_front();
            checkOutput(item, observe(item.sel));
         end
      end
   end

   initial begin
      $display("[TB] start");
      @(posedge clk);
      #1;

      // ---------------- dutA: MEM_WAIT=1, bne legal, skip illegal, CNT_W=4
      applyStimulus(0, T_FETCH, OPC_R, 0, 1, 0, 0);
      applyStimulus(0, T_FETCH, OPC_R, 0, 1, 0, 0);

      // lw: 2 wait cycles in FETCH, 3 in MEMRD -> 10 cycles
      applyStimulus(0, T_FETCH,  OPC_LW, 0, 0, 1, 0);
      applyStimulus(0, T_FETCH,  OPC_LW, 0, 0, 1, 0);
      applyStimulus(0, T_FETCH,  OPC_LW, 0, 1, 1, 0);
      applyStimulus(0, T_DECODE, OPC_LW, 0, 1, 1, 0);
      applyStimulus(0, T_MEMADR, OPC_LW, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus(0, T_MEMRD, OPC_LW, 0, 0, 1, 0);
      applyStimulus(0, T_MEMRD,  OPC_LW, 0, 1, 1, 0);
      applyStimulus(0, T_MEMWB,  OPC_LW, 0, 1, 1, 0);

      // R-type
      applyStimulus(0, T_FETCH,  OPC_R, 0, 1, 1, 1);
      applyStimulus(0, T_DECODE, OPC_R, 0, 1, 1, 1);
      applyStimulus(0, T_EXEC,   OPC_R, 0, 1, 1, 1);
      applyStimulus(0, T_ALUWB,  OPC_R, 0, 1, 1, 1);

      // beq taken / not taken, bne taken / not taken
      applyStimulus(0, T_FETCH,  OPC_BEQ, 1, 1, 1, 2);
      applyStimulus(0, T_DECODE, OPC_BEQ, 1, 1, 1, 2);
      applyStimulus(0, T_BEQ,    OPC_BEQ, 1, 1, 1, 2);
      applyStimulus(0, T_FETCH,  OPC_BEQ, 0, 1, 1, 3);
      applyStimulus(0, T_DECODE, OPC_BEQ, 0, 1, 1, 3);
      applyStimulus(0, T_BEQ,    OPC_BEQ, 0, 1, 1, 3);
      applyStimulus(0, T_FETCH,  OPC_BNE, 0, 1, 1, 4);
      applyStimulus(0, T_DECODE, OPC_BNE, 0, 1, 1, 4);
      applyStimulus(0, T_BNE,    OPC_BNE, 0, 1, 1, 4);
      applyStimulus(0, T_FETCH,  OPC_BNE, 1, 1, 1, 5);
      applyStimulus(0, T_DECODE, OPC_BNE, 1, 1, 1, 5);
      applyStimulus(0, T_BNE,    OPC_BNE, 1, 1, 1, 5);

      // addi
      applyStimulus(0, T_FETCH,  OPC_ADDI, 0, 1, 1, 6);
      applyStimulus(0, T_DECODE, OPC_ADDI, 0, 1, 1, 6);
      applyStimulus(0, T_ADDIEX, OPC_ADDI, 0, 1, 1, 6);
      applyStimulus(0, T_ADDIWB, OPC_ADDI, 0, 1, 1, 6);

      // illegal opcode is skipped without retiring
      applyStimulus(0, T_FETCH,   OPC_BAD, 0, 1, 1, 7);
      applyStimulus(0, T_DECODE,  OPC_BAD, 0, 1, 1, 7);
      applyStimulus(0, T_ILLEGAL, OPC_BAD, 0, 1, 1, 7);

      // sw completing normally
      applyStimulus(0, T_FETCH,  OPC_SW, 0, 1, 1, 7);
      applyStimulus(0, T_DECODE, OPC_SW, 0, 1, 1, 7);
      applyStimulus(0, T_MEMADR, OPC_SW, 0, 1, 1, 7);
      applyStimulus(0, T_MEMWR,  OPC_SW, 0, 1, 1, 7);

      // sw stalled 4 cycles then reset mid-write
      applyStimulus(0, T_FETCH,  OPC_SW, 0, 1, 1, 8);
      applyStimulus(0, T_DECODE, OPC_SW, 0, 1, 1, 8);
      applyStimulus(0, T_MEMADR, OPC_SW, 0, 1, 1, 8);
      for (int i = 0; i < 4; i++)
         applyStimulus(0, T_MEMWR, OPC_SW, 0, 0, 1, 8);
      applyStimulus(0, T_MEMWR, OPC_SW, 0, 0, 0, 8);

      // 16 jumps wrap the 4-bit counter back to 0
      for (int k = 0; k < 16; k++) begin
         applyStimulus(0, T_FETCH,  OPC_J, 0, 1, 1, k);
         applyStimulus(0, T_DECODE, OPC_J, 0, 1, 1, k);
         applyStimulus(0, T_JUMP,   OPC_J, 0, 1, 1, k);
      end
      applyStimulus(0, T_FETCH, OPC_J, 0, 1, 0, 0);

      // ---------------- dutB: MEM_WAIT=0, no bne, trap on illegal
      applyStimulus(1, T_FETCH, OPC_R, 0, 0, 0, 0);

      // mem_ready held low is ignored: R-type 4 cycles, lw 5 cycles
      applyStimulus(1, T_FETCH,  OPC_R, 0, 0, 1, 0);
      applyStimulus(1, T_DECODE, OPC_R, 0, 0, 1, 0);
      applyStimulus(1, T_EXEC,   OPC_R, 0, 0, 1, 0);
      applyStimulus(1, T_ALUWB,  OPC_R, 0, 0, 1, 0);
      applyStimulus(1, T_FETCH,  OPC_LW, 0, 0, 1, 1);
      applyStimulus(1, T_DECODE, OPC_LW, 0, 0, 1, 1);
      applyStimulus(1, T_MEMADR, OPC_LW, 0, 0, 1, 1);
      applyStimulus(1, T_MEMRD,  OPC_LW, 0, 0, 1, 1);
      applyStimulus(1, T_MEMWB,  OPC_LW, 0, 0, 1, 1);

      // bne is illegal here and traps into HALT
      applyStimulus(1, T_FETCH,   OPC_BNE, 0, 1, 1, 2);
      applyStimulus(1, T_DECODE,  OPC_BNE, 0, 1, 1, 2);
      applyStimulus(1, T_ILLEGAL, OPC_BNE, 0, 1, 1, 2);
      for (int i = 0; i < 20; i++)
         applyStimulus(1, T_HALT, (i % 2 == 0) ? OPC_J : OPC_R, i[0], 1, 1, 2);
      applyStimulus(1, T_HALT, OPC_J, 0, 1, 0, 2);

      // back to normal after reset
      applyStimulus(1, T_FETCH,  OPC_J, 0, 1, 1, 0);
      applyStimulus(1, T_DECODE, OPC_J, 0, 1, 1, 0);
      applyStimulus(1, T_JUMP,   OPC_J, 0, 1, 1, 0);
      applyStimulus(1, T_FETCH,  OPC_J, 0, 1, 0, 1);

      @(negedge clk);
      #1;
      assertCount++;
      if (sbQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               assertCount, failCount);
      $finish;
   end

endmodule
